// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: latches a parallel pattern and shifts it out MSB-first,
// one bit per prescaler period (auto) or per step pulse (manual), one-shot or looping.
module serial_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     hold,
  input  logic                     repeat_mode,
  input  logic                     manual,
  input  logic                     step,
  input  logic [WIDTH-1:0]         pattern,
  output logic                     x,
  output logic                     bit_tick,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int IW = $clog2(WIDTH);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] pat_q, pat_q_n;
  logic [PW-1:0]    pcnt, pcnt_n;
  logic [IW-1:0]    bit_idx_n;
  logic             x_n, tick_n, adv;

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    pat_q_n   = pat_q;
    pcnt_n    = pcnt;
    bit_idx_n = bit_idx;
    x_n       = x;
    tick_n    = 1'b0;
    adv       = 1'b0;
    if (stop) begin
      state_n   = IDLE;
      x_n       = 1'b0;
      bit_idx_n = '0;
      pcnt_n    = '0;
    end else if (start) begin
      state_n   = RUN;
      pat_q_n   = pattern;
      shreg_n   = pattern;
      x_n       = pattern[WIDTH-1];
      bit_idx_n = '0;
      pcnt_n    = '0;
      tick_n    = 1'b1;
    end else if (state == RUN && !hold) begin
      // Manual mode parks the prescaler at 0 so a return to auto starts a full bit period.
      adv = manual ? step : (pcnt == PW'(DIV - 1));
      if (manual || adv) pcnt_n = '0;
      else               pcnt_n = pcnt + PW'(1);
      if (adv) begin
        if (bit_idx != IW'(WIDTH - 1)) begin
          shreg_n   = shreg << 1;
          x_n       = shreg[WIDTH-2];
          bit_idx_n = bit_idx + IW'(1);
          tick_n    = 1'b1;
        end else if (repeat_mode) begin
          shreg_n   = pat_q;
          x_n       = pat_q[WIDTH-1];
          bit_idx_n = '0;
          tick_n    = 1'b1;
        end else begin
          state_n = DONE;
          x_n     = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      pat_q    <= '0;
      pcnt     <= '0;
      bit_idx  <= '0;
      x        <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      pat_q    <= pat_q_n;
      pcnt     <= pcnt_n;
      bit_idx  <= bit_idx_n;
      x        <= x_n;
      bit_tick <= tick_n;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen: randomized patterns checked against a
// bit-period arithmetic model of the expected serial stream.
module tb_serial_pattern_gen;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst, start, stop, hold, rpt, manual, step;
  logic [W-1:0] pattern;
  logic         x, bit_tick, busy, done;
  logic [2:0]   bit_idx;
  logic [6:0]   exp_v;
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  serial_pattern_gen #(.WIDTH(W), .DIV(D)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
    .repeat_mode(rpt), .manual(manual), .step(step), .pattern(pattern),
    .x(x), .bit_tick(bit_tick), .bit_idx(bit_idx), .busy(busy), .done(done)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected {x, bit_tick, bit_idx, busy, done} after 'eff' unheld bit-clock cycles since start.
  function automatic logic [6:0] expect_at(logic [W-1:0] pat, int eff, bit loop, bit tick_ok, int div);
    int b;
    b = eff / div;
    if (loop) b = b % W;
    if (b < W) return {pat[W-1-b], tick_ok && (eff % div == 0), 3'(b), 1'b1, 1'b0};
    return {1'b0, 1'b0, 3'(W-1), 1'b0, 1'b1};
  endfunction

  task automatic do_start(input logic [W-1:0] pat, input logic loop);
    pattern = pat;
    rpt     = loop;
    start   = 1'b1;
    cyc();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_cmp++;
    if ({x, bit_tick, bit_idx, busy, done} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_init got=%b want=%b", {x, bit_tick, bit_idx, busy, done}, 7'b0);
    end
    do_start(W'($urandom) | 8'h80, 1'b0);
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_cmp++;
    if ({x, bit_tick, bit_idx, busy, done} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_midrun got=%b want=%b", {x, bit_tick, bit_idx, busy, done}, 7'b0);
    end
    cyc();
    n_cmp++;
    if ({x, bit_tick, bit_idx, busy, done} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_stays_idle got=%b want=%b", {x, bit_tick, bit_idx, busy, done}, 7'b0);
    end
  endtask

  task automatic test_oneshot();
    logic [W-1:0] pat;
    for (int r = 0; r < 4; r++) begin
      pat = (r == 0) ? 8'b1101_0110 : W'($urandom);
      do_start(pat, 1'b0);
      for (int k = 0; k < W*D + 4; k++) begin
        exp_v = expect_at(pat, k, 1'b0, 1'b1, D);
        n_cmp++;
        if ({x, bit_tick, bit_idx, busy, done} !== exp_v) begin
          n_err++;
          $display("FAIL oneshot pat=%h k=%0d got=%b want=%b", pat, k, {x, bit_tick, bit_idx, busy, done}, exp_v);
        end
        cyc();
      end
    end
  endtask

  task automatic test_repeat();
    logic [W-1:0] pat;
    for (int r = 0; r < 2; r++) begin
      pat = (r == 0) ? 8'hA5 : W'($urandom);
      do_start(pat, 1'b1);
      for (int k = 0; k < 3*W*D; k++) begin
        exp_v = expect_at(pat, k, 1'b1, 1'b1, D);
        n_cmp++;
        if ({x, bit_tick, bit_idx, busy, done} !== exp_v) begin
          n_err++;
          $display("FAIL repeat pat=%h k=%0d got=%b want=%b", pat, k, {x, bit_tick, bit_idx, busy, done}, exp_v);
        end
        if (k == W*D/2) pattern = ~pat;
        cyc();
      end
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      rpt  = 1'b0;
      n_cmp++;
      if ({x, bit_tick, bit_idx, busy, done} !== 7'b0) begin
        n_err++;
        $display("FAIL repeat_stop got=%b want=%b", {x, bit_tick, bit_idx, busy, done}, 7'b0);
      end
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] pat;
    logic         h;
    int           eff;
    pat = W'($urandom);
    do_start(pat, 1'b0);
    eff = 0;
    for (int i = 0; i < 70; i++) begin
      h = (i >= 13 && i < 23) || (i >= 23 && $urandom_range(3) == 0);
      hold = h;
      cyc();
      if (!h) eff++;
      exp_v = expect_at(pat, eff, 1'b0, !h, D);
      n_cmp++;
      if ({x, bit_tick, bit_idx, busy, done} !== exp_v) begin
        n_err++;
        $display("FAIL hold pat=%h i=%0d got=%b want=%b", pat, i, {x, bit_tick, bit_idx, busy, done}, exp_v);
      end
    end
    hold = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_manual();
    logic [W-1:0] pat;
    logic         s;
    int           steps;
    manual = 1'b1;
    pat = W'($urandom);
    do_start(pat, 1'b0);
    steps = 0;
    for (int i = 0; i < 28; i++) begin
      s = (i < 6) ? (i % 2 == 1) : 1'($urandom_range(1));
      step = s;
      cyc();
      step = 1'b0;
      if (s) steps++;
      exp_v = expect_at(pat, steps, 1'b0, s, 1);
      n_cmp++;
      if ({x, bit_tick, bit_idx, busy, done} !== exp_v) begin
        n_err++;
        $display("FAIL manual pat=%h i=%0d got=%b want=%b", pat, i, {x, bit_tick, bit_idx, busy, done}, exp_v);
      end
    end
    manual = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    stop  = 1'b1;
    pattern = 8'hFF;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    n_cmp++;
    if ({x, bit_tick, bit_idx, busy, done} !== 7'b0) begin
      n_err++;
      $display("FAIL start_stop got=%b want=%b", {x, bit_tick, bit_idx, busy, done}, 7'b0);
    end
    do_start(8'h00, 1'b0);
    repeat (5) cyc();
    do_start(8'hFF, 1'b0);
    n_cmp++;
    if ({x, bit_tick, bit_idx, busy, done} !== 7'b1100010) begin
      n_err++;
      $display("FAIL restart got=%b want=%b", {x, bit_tick, bit_idx, busy, done}, 7'b1100010);
    end
    step = 1'b1;
    cyc();
    step = 1'b0;
    exp_v = expect_at(8'hFF, 1, 1'b0, 1'b1, D);
    n_cmp++;
    if ({x, bit_tick, bit_idx, busy, done} !== exp_v) begin
      n_err++;
      $display("FAIL step_auto got=%b want=%b", {x, bit_tick, bit_idx, busy, done}, exp_v);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    step = 1'b1;
    cyc();
    step = 1'b0;
    n_cmp++;
    if ({x, bit_tick, bit_idx, busy, done} !== 7'b0) begin
      n_err++;
      $display("FAIL step_idle got=%b want=%b", {x, bit_tick, bit_idx, busy, done}, 7'b0);
    end
  endtask

  task automatic test_integration();
    logic [W-1:0] pat;
    logic         q[$];
    logic [3:0]   wr, wm;
    logic         yr, ym;
    pat = 8'b0111_0100;
    do_start(pat, 1'b0);
    for (int k = 0; k < W*D + 2; k++) begin
      if (bit_tick) q.push_back(x);
      cyc();
    end
    n_cmp++;
    if (q.size() != W || done !== 1'b1) begin
      n_err++;
      $display("FAIL integ_bits got=%0d/%b want=%0d/1", q.size(), done, W);
    end
    wr = '0;
    wm = '0;
    for (int i = 0; i < W && i < q.size(); i++) begin
      wr = {wr[2:0], q[i]};
      wm = {wm[2:0], pat[W-1-i]};
      yr = (i >= 3) && (wr == 4'b0100);
      ym = (i >= 3) && (wm == 4'b0100);
      n_cmp++;
      if (yr !== ym) begin
        n_err++;
        $display("FAIL integ_y bit=%0d got=%b want=%b", i, yr, ym);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
    rpt = 1'b0; manual = 1'b0; step = 1'b0; pattern = '0;
    cyc();
    test_reset();
    test_oneshot();
    test_repeat();
    test_hold();
    test_manual();
    test_back_to_back();
    test_integration();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
